// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: default line parameters, the transmit framing
// state encoding and the bit-period divider helper. Imported by uart_tx_fifo
// and reused by the receive side.
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int DEFAULT_CLK_HZ = 100_000_000;
   localparam int DEFAULT_BAUD   = 115_200;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   // Bit period in clock cycles, integer-truncated.
   function automatic int calc_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered storage and a first-word-fall-through
// head: o_head always shows the oldest entry while o_empty is low.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_push       write i_data (taken when not full, or when popping in the
//                same cycle)
//   i_data       write data
//   i_pop        discard the head entry (ignored when empty)
//   o_head       oldest entry
//   o_count      number of stored entries, 0..DEPTH
//   o_full       o_count == DEPTH
//   o_empty      o_count == 0
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   // A simultaneous pop frees a slot, so a push is legal even when full.
   assign w_push_ok = i_push & (~o_full | i_pop);
   assign w_pop_ok  = i_pop & ~o_empty;

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == (AW+1)'(0));

   // Storage write; contents need no reset since the count gates reads.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointer and occupancy tracking; pointers wrap because DEPTH is 2^AW.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Buffered 8-N-1 / 8-N-2 UART transmitter. Bytes enter a FIFO over a
// valid/ready handshake and are shifted out LSB-first; queued frames follow
// each other with no idle gap.
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    producer has a byte on in_data
//   in_data     byte to send
//   in_ready    FIFO can accept (combinational from the level)
//   tx          serial line, registered, idles high
//   busy        FIFO non-empty or frame in progress (registered)
//   fifo_level  bytes queued, excluding the one being shifted
// -----------------------------------------------------------------------------
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = DEFAULT_CLK_HZ,
   parameter int BAUD       = DEFAULT_BAUD,
   parameter int FIFO_DEPTH = 16,
   parameter int STOP_BITS  = 1
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic [7:0]                    in_data,
   output logic                          in_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int             DIV           = calc_div(CLK_HZ, BAUD);
   localparam int             CW            = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]  BAUD_RELOAD   = CW'(DIV - 1);
   localparam logic [2:0]     LAST_DATA_BIT = 3'd7;
   localparam logic [2:0]     LAST_STOP_BIT = 3'(STOP_BITS - 1);

   tx_state_t                 r_state;
   tx_state_t                 w_state_nxt;
   logic [CW-1:0]             r_baud;
   logic [CW-1:0]             w_baud_nxt;
   logic [2:0]                r_bit;
   logic [2:0]                w_bit_nxt;
   logic [7:0]                r_shift;
   logic [7:0]                w_shift_nxt;
   logic                      r_tx;
   logic                      w_tx_nxt;
   logic                      r_busy;
   logic                      w_busy_nxt;

   logic                      w_push;
   logic                      w_pop;
   logic [7:0]                w_head;
   logic [$clog2(FIFO_DEPTH):0] w_count;
   logic                      w_full;
   logic                      w_empty;

   assign in_ready   = ~w_full;
   assign w_push     = in_valid & in_ready;
   assign tx         = r_tx;
   assign busy       = r_busy;
   assign fifo_level = w_count;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (in_data),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Framing FSM state, baud/bit counters, shifter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_bit   <= 3'd0;
         r_shift <= 8'h00;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_tx    <= w_tx_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // Next-state logic. tx is computed one cycle ahead so that the registered
   // line changes on the same edge as the state it belongs to.
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_tx_nxt    = r_tx;
      w_pop       = 1'b0;

      case (r_state)
         IDLE: begin
            w_tx_nxt = 1'b1;
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_shift_nxt = w_head;
               w_baud_nxt  = BAUD_RELOAD;
               w_bit_nxt   = 3'd0;
               w_tx_nxt    = 1'b0;
               w_state_nxt = START;
            end else begin
               w_state_nxt = IDLE;
            end
         end

         START: begin
            if (r_baud == '0) begin
               w_baud_nxt  = BAUD_RELOAD;
               w_bit_nxt   = 3'd0;
               w_tx_nxt    = r_shift[0];
               w_state_nxt = DATA;
            end else begin
               w_baud_nxt  = r_baud - CW'(1);
            end
         end

         DATA: begin
            if (r_baud == '0) begin
               w_baud_nxt = BAUD_RELOAD;
               if (r_bit == LAST_DATA_BIT) begin
                  w_bit_nxt   = 3'd0;
                  w_tx_nxt    = 1'b1;
                  w_state_nxt = STOP;
               end else begin
                  // Line shows shift[0]; after shifting, the next bit is the
                  // current shift[1].
                  w_bit_nxt   = r_bit + 3'd1;
                  w_shift_nxt = {1'b0, r_shift[7:1]};
                  w_tx_nxt    = r_shift[1];
               end
            end else begin
               w_baud_nxt = r_baud - CW'(1);
            end
         end

         STOP: begin
            if (r_baud == '0) begin
               w_baud_nxt = BAUD_RELOAD;
               if (r_bit == LAST_STOP_BIT) begin
                  w_bit_nxt = 3'd0;
                  // Chain straight into the next start bit when data waits.
                  if (!w_empty) begin
                     w_pop       = 1'b1;
                     w_shift_nxt = w_head;
                     w_tx_nxt    = 1'b0;
                     w_state_nxt = START;
                  end else begin
                     w_tx_nxt    = 1'b1;
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
               end
            end else begin
               w_baud_nxt = r_baud - CW'(1);
            end
         end

         default: begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // busy covers an active frame plus anything queued, including a byte
   // arriving on this very edge.
   always_comb begin
      w_busy_nxt = (w_state_nxt != IDLE) | ~w_empty | w_push;
   end

endmodule
